// File: rtl/lfsr_pkg.sv
// Shared definitions for the 32-bit LFSR pattern generator and checker.
// Polynomial x^32+x^22+x^2+x+1; the new LSB is the XOR of state bits 31, 21, 1 and 0.
package lfsr_pkg;

    localparam int unsigned LFSR_W = 32;

    localparam int unsigned TAP_A = 31;
    localparam int unsigned TAP_B = 21;
    localparam int unsigned TAP_C = 1;
    localparam int unsigned TAP_D = 0;

    // Evaluates to 32'h80200003.
    localparam logic [LFSR_W-1:0] POLY_MASK = (32'd1 << TAP_A) | (32'd1 << TAP_B) |
                                              (32'd1 << TAP_C) | (32'd1 << TAP_D);

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;

    function automatic logic lfsr_next_bit(input logic [LFSR_W-1:0] s);
        return ^(s & POLY_MASK);
    endfunction

endpackage

// File: rtl/lfsr_err_counter.sv
// Saturating error counter: a clear takes effect first, then an increment in the
// same cycle is applied on top of it.
module lfsr_err_counter #(
    parameter int unsigned ERR_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc,
    output logic [ERR_W-1:0] count
);

    logic [ERR_W-1:0] count_q;
    logic [ERR_W-1:0] count_d;
    logic [ERR_W-1:0] base;

    always_comb begin
        base    = clear ? '0 : count_q;
        count_d = base;
        if (inc && (base != {ERR_W{1'b1}})) begin
            count_d = base + ERR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/lfsr_checker.sv
// Receive-side checker for the 32-bit LFSR generator: self-seeds, locks, counts bit errors.
// Optional LFSR_CHECKER_BITCNT_EN adds a bit_count output of bits checked while locked.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int unsigned LOCK_COUNT = 32,
    parameter int unsigned LOSS_COUNT = 8,
    parameter int unsigned ERR_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             err_clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       state,
    output logic [31:0]      expected
`ifdef LFSR_CHECKER_BITCNT_EN
    ,
    output logic [31:0]      bit_count
`endif
);

    localparam int unsigned RUN_MAX = (LOCK_COUNT > LOSS_COUNT) ? LOCK_COUNT : LOSS_COUNT;
    localparam int unsigned RUN_W   = $clog2(RUN_MAX + 1);

    localparam logic [RUN_W-1:0] LOCK_LAST = RUN_W'(LOCK_COUNT - 1);
    localparam logic [RUN_W-1:0] LOSS_LAST = RUN_W'(LOSS_COUNT - 1);

    chk_state_t        state_q, state_d;
    logic [31:0]       sr_q, sr_d;
    logic [4:0]        fill_q, fill_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic              locked_q, locked_d;
    logic              pulse_q, pulse_d;
    logic              err_inc;
    logic              pred;

    assign pred = lfsr_next_bit(sr_q);

    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        fill_d   = fill_q;
        run_d    = run_q;
        locked_d = locked_q;
        pulse_d  = 1'b0;
        err_inc  = 1'b0;

        if (bit_valid) begin
            unique case (state_q)
                SEED: begin
                    sr_d = {sr_q[30:0], bit_in};
                    if (fill_q == 5'd31) begin
                        state_d = SYNC;
                        fill_d  = '0;
                        run_d   = '0;
                    end else begin
                        fill_d = fill_q + 5'd1;
                    end
                end
                SYNC: begin
                    sr_d = {sr_q[30:0], bit_in};
                    // An all-zero register predicts zeros forever, so never credit it.
                    if ((bit_in == pred) && (sr_q != '0)) begin
                        if (run_q == LOCK_LAST) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                            run_d    = '0;
                        end else begin
                            run_d = run_q + RUN_W'(1);
                        end
                    end else begin
                        run_d = '0;
                    end
                end
                LOCKED: begin
                    // Free-run on the prediction so a single flipped bit costs one error.
                    sr_d = {sr_q[30:0], pred};
                    if (bit_in != pred) begin
                        pulse_d = 1'b1;
                        err_inc = 1'b1;
                        if (run_q == LOSS_LAST) begin
                            state_d  = SEED;
                            locked_d = 1'b0;
                            fill_d   = '0;
                            run_d    = '0;
                        end else begin
                            run_d = run_q + RUN_W'(1);
                        end
                    end else begin
                        run_d = '0;
                    end
                end
                default: begin
                    state_d  = SEED;
                    locked_d = 1'b0;
                    fill_d   = '0;
                    run_d    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= SEED;
            sr_q     <= '0;
            fill_q   <= '0;
            run_q    <= '0;
            locked_q <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            fill_q   <= fill_d;
            run_q    <= run_d;
            locked_q <= locked_d;
            pulse_q  <= pulse_d;
        end
    end

    lfsr_err_counter #(
        .ERR_W (ERR_W)
    ) u_err_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (err_clear),
        .inc   (err_inc),
        .count (err_count)
    );

`ifdef LFSR_CHECKER_BITCNT_EN
    logic [31:0] bit_count_q;
    logic        bit_checked;

    assign bit_checked = bit_valid && (state_q == LOCKED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_count_q <= '0;
        end else if (err_clear || bit_checked) begin
            bit_count_q <= (err_clear ? 32'd0 : bit_count_q) + 32'(bit_checked);
        end
    end

    assign bit_count = bit_count_q;
`endif

    assign locked    = locked_q;
    assign err_pulse = pulse_q;
    assign state     = state_q;
    assign expected  = sr_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Self-checking bench for lfsr_checker: directed sequence with a generator model and
// random valid gaps; the checker is built with a 4-bit error counter.
module tb_lfsr_checker;

    localparam int unsigned ERR_W = 4;
    localparam int unsigned SAT   = 15;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             bit_in    = 1'b0;
    logic             bit_valid = 1'b0;
    logic             err_clear = 1'b0;
    logic             locked;
    logic             err_pulse;
    logic [ERR_W-1:0] err_count;
    logic [1:0]       state;
    logic [31:0]      expected;
`ifdef LFSR_CHECKER_BITCNT_EN
    logic [31:0]      bit_count;
`endif

    int          errors = 0;
    int          checks = 0;
    logic [31:0] gen;

    lfsr_checker #(
        .LOCK_COUNT (32),
        .LOSS_COUNT (8),
        .ERR_W      (ERR_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .err_clear (err_clear),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .state     (state),
        .expected  (expected)
`ifdef LFSR_CHECKER_BITCNT_EN
        ,
        .bit_count (bit_count)
`endif
    );

    always #5 clk = ~clk;

    // Generator model: shift left, new LSB = s[31]^s[21]^s[1]^s[0].
    function automatic logic [31:0] gen_step(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input logic b, input logic v, input logic clr);
        bit_in    = b;
        bit_valid = v;
        err_clear = clr;
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
        err_clear = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_locked"}, 32'(locked), 32'd0);
        check({tag, "_state"}, 32'(state), 32'd0);
        check({tag, "_errcnt"}, 32'(err_count), 32'd0);
        check({tag, "_expected"}, expected, 32'd0);
        check({tag, "_pulse"}, 32'(err_pulse), 32'd0);
    endtask

    task automatic async_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check_reset_values(tag);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Feed 64 clean bits back to back; lock must appear exactly after the 64th.
    task automatic acquire(input string tag);
        for (int i = 1; i <= 64; i++) begin
            gen = gen_step(gen);
            tick(gen[0], 1'b1, 1'b0);
            check({tag, "_lock_pt"}, 32'(locked), 32'(i >= 64));
            if (i == 32) check({tag, "_sync"}, 32'(state), 32'd1);
        end
        check({tag, "_state"}, 32'(state), 32'd2);
        check({tag, "_expected"}, expected, gen);
    endtask

    initial begin
        int n;
        int cyc;
        logic v;

        // Power-on reset held across clock edges.
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("por");
        rst_n = 1'b1;

        // Clean acquisition from seed all-ones.
        gen = 32'hFFFF_FFFF;
        acquire("clean");
        check("clean_errcnt", 32'(err_count), 32'd0);

        // Single flipped bit, 100 bits after lock.
        for (int i = 1; i < 100; i++) begin
            gen = gen_step(gen);
            tick(gen[0], 1'b1, 1'b0);
            check("track_expected", expected, gen);
            check("track_pulse", 32'(err_pulse), 32'd0);
        end
        gen = gen_step(gen);
        tick(~gen[0], 1'b1, 1'b0);
        check("single_pulse", 32'(err_pulse), 32'd1);
        check("single_errcnt", 32'(err_count), 32'd1);
        check("single_locked", 32'(locked), 32'd1);
        check("single_expected", expected, gen);
        for (int i = 0; i < 20; i++) begin
            gen = gen_step(gen);
            tick(gen[0], 1'b1, 1'b0);
            check("after_single_pulse", 32'(err_pulse), 32'd0);
        end
        check("after_single_errcnt", 32'(err_count), 32'd1);

        // Clear alone, with a valid gap: lock unaffected.
        tick(1'b0, 1'b0, 1'b1);
        check("clear_errcnt", 32'(err_count), 32'd0);
        check("clear_locked", 32'(locked), 32'd1);

        // Eight consecutive inverted bits drop lock.
        for (int k = 1; k <= 8; k++) begin
            gen = gen_step(gen);
            tick(~gen[0], 1'b1, 1'b0);
            check("loss_errcnt", 32'(err_count), 32'(k));
            check("loss_pulse", 32'(err_pulse), 32'd1);
            if (k < 8) check("loss_still_locked", 32'(locked), 32'd1);
        end
        check("loss_state", 32'(state), 32'd0);
        check("loss_locked", 32'(locked), 32'd0);
        acquire("relock");
        check("relock_errcnt", 32'(err_count), 32'd8);

        // Mid-stream async reset, then acquisition with ~30% valid duty.
        async_reset("mid_rst");
        gen = $urandom | 32'h1;
        n   = 0;
        cyc = 0;
        while (n < 74 && cyc < 5000) begin
            v = ($urandom_range(0, 99) < 30);
            if (v) begin
                gen = gen_step(gen);
                n++;
                tick(gen[0], 1'b1, 1'b0);
            end else begin
                tick(1'($urandom), 1'b0, 1'b0);
            end
            cyc++;
            check("gap_lock_pt", 32'(locked), 32'(n >= 64));
            check("gap_pulse", 32'(err_pulse), 32'd0);
        end
        check("gap_budget", 32'(n), 32'd74);
        check("gap_expected", expected, gen);

        // All-zero stream: seeds to zero, sits in SYNC forever.
        async_reset("zero_rst");
        for (int i = 0; i < 300; i++) tick(1'b0, 1'b1, 1'b0);
        check("zero_state", 32'(state), 32'd1);
        check("zero_locked", 32'(locked), 32'd0);
        check("zero_expected", expected, 32'd0);
        check("zero_errcnt", 32'(err_count), 32'd0);

        // Saturation of the 4-bit counter with isolated errors.
        async_reset("sat_rst");
        gen = $urandom | 32'h1;
        acquire("sat_acq");
        for (int k = 1; k <= 20; k++) begin
            gen = gen_step(gen);
            tick(~gen[0], 1'b1, 1'b0);
            check("sat_errcnt", 32'(err_count), 32'((k > SAT) ? SAT : k));
            check("sat_pulse", 32'(err_pulse), 32'd1);
            for (int j = 0; j < 3; j++) begin
                gen = gen_step(gen);
                tick(gen[0], 1'b1, 1'b0);
            end
            check("sat_gap_pulse", 32'(err_pulse), 32'd0);
        end
        check("sat_final", 32'(err_count), 32'(SAT));
        check("sat_locked", 32'(locked), 32'd1);

        // Clear coincident with an error: clear first, then count.
        gen = gen_step(gen);
        tick(~gen[0], 1'b1, 1'b1);
        check("clr_err_errcnt", 32'(err_count), 32'd1);
        check("clr_err_pulse", 32'(err_pulse), 32'd1);
        tick(1'b0, 1'b0, 1'b0);
        check("idle_pulse", 32'(err_pulse), 32'd0);
        check("idle_errcnt", 32'(err_count), 32'd1);
        check("idle_expected", expected, gen);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lfsr_checker.md
Name: lfsr_checker

Overview:
- Receive side of the 32-bit LFSR pattern generator. Consumes the generator's serial bitstream, one bit per valid cycle; the bit is the generator's new LSB (its feedback bit).
- Self-seeds from the incoming data, then declares lock and counts bit errors against the predicted sequence.
- Used for on-chip and loopback link/BIST checking next to the generator.
- Fixed polynomial x^32+x^22+x^2+x+1; the next bit is the XOR of state bits 31, 21, 1 and 0.

Parameters:
- LOCK_COUNT, 32: consecutive correct predictions in SYNC required to assert lock.
- LOSS_COUNT, 8: consecutive mismatches in LOCKED that drop lock.
- ERR_W, 16: width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- bit_in  input  1  received stream bit.
- bit_valid  input  1  bit_in is sampled only when high; gaps of any length allowed.
- err_clear  input  1  synchronous clear of err_count; no effect on lock state.
- locked  output  1  high in LOCKED.
- err_pulse  output  1  one-cycle pulse per counted error.
- err_count  output  ERR_W  saturating error count.
- state  output  2  SEED=0, SYNC=1, LOCKED=2.
- expected  output  32  current 32-bit shift state; matches the generator's register when locked.

Behaviour:
- Reset (async assert, sync release): sr=0, fill_cnt=0, run_cnt=0, state=SEED, locked=0, err_pulse=0, err_count=0.
- Prediction: pred = sr[31]^sr[21]^sr[1]^sr[0], where sr[0] holds the most recent bit.
- Cycles with bit_valid=0: no state changes; err_pulse=0.
- SEED:
  - On each valid bit: sr <= {sr[30:0], bit_in}, fill_cnt++.
  - After the 32nd valid bit: go to SYNC, run_cnt=0.
- SYNC:
  - On each valid bit: shift in bit_in (self-synchronising).
  - If bit_in==pred, run_cnt++; otherwise run_cnt=0.
  - All-zero guard: if sr==0 before the shift, the bit is not counted as a match and run_cnt=0. Zero lock-up never locks.
  - When run_cnt reaches LOCK_COUNT: go to LOCKED, locked=1 in the same registered update, run_cnt=0.
  - No errors are counted in SYNC.
- LOCKED:
  - On each valid bit: sr <= {sr[30:0], pred}. The checker free-runs, so one flipped bit yields exactly one error.
  - Mismatch: err_pulse=1 next cycle; err_count+1, saturating at 2^ERR_W-1; run_cnt++.
  - Match: run_cnt=0.
  - When run_cnt reaches LOSS_COUNT: go to SEED, locked=0, fill_cnt=0. The error that triggered loss is still counted.
- err_clear with a simultaneous error: err_count=1 (clear first, then count). err_pulse still fires.
- Latency: all outputs are registered and reflect a valid bit one cycle after the clock edge that samples it.
- Async reset in any state returns immediately to the reset values.

Optional Feature:
- Macro: LFSR_CHECKER_BITCNT_EN.
- With the macro defined:
  - Adds output bit_count, 32 bits: number of valid bits checked while in LOCKED (includes error bits).
  - Wraps modulo 2^32.
  - Cleared by reset and by err_clear.
  - Frozen outside LOCKED.
- Without it: the port and its register are absent; all other behaviour is identical.

Decomposition:
- Package lfsr_pkg holds:
  - POLY_MASK = 32'h80200003.
  - The tap index constants 31, 21, 1 and 0.
  - The state enum chk_state_t (SEED, SYNC, LOCKED).
  - A function lfsr_next_bit(state). The generator shares this package.
- One sub-module, lfsr_err_counter: a saturating ERR_W counter with clear and increment inputs, clear having priority and then counting. It is instantiated once.

Test Plan:
- Reset check: drive rst_n low mid-stream -> immediately locked=0, state=0, err_count=0, expected=0.
- Clean acquisition: feed the generator stream from seed 32'hFFFFFFFF (first bit 0), valid every cycle -> locked rises on the output after valid bit 64 (32 + LOCK_COUNT); expected equals the generator register thereafter; err_count=0.
- Single error: flip one bit 100 bits after lock -> one err_pulse, err_count=1, locked stays 1, no further errors.
- Loss of lock: invert 8 consecutive bits -> err_count=8, then state=SEED and locked=0. Resume the clean stream -> relock after 64 more valid bits.
- Gaps and zeros:
  - Random bit_valid duty 30% -> same lock point measured in valid bits.
  - An all-zero stream stays in SYNC and never locks.
- Saturation and clear:
  - With ERR_W=4, inject 20 errors spaced apart -> err_count=15.
  - err_clear together with an error -> err_count=1.
